keypad_matrix_scanner: RTL and testbench
========================================

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 SCAN_DIV, 5000, clk cycles each column is driven before its rows are sampled.
REQ-002 DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release.
REQ-003 REPEAT_DELAY, 50, full scans from accepted press to first auto-repeat; used only with KEYPAD_REPEAT_EN.
REQ-004 REPEAT_RATE, 10, full scans between subsequent auto-repeats; used only with KEYPAD_REPEAT_EN.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 key_col  output  4  column drive, active-low one-hot.
REQ-008 key_row  input  4  row sense, active-low, externally pulled up.
REQ-009 key_code  output  4  code of last accepted key, row*4+col.
REQ-010 key_valid  output  1  one-clk pulse per accepted key event.
REQ-011 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-012 Divider SHALL count 0..SCAN_DIV-1; at terminal count, key_row SHALL be sampled for the current column and the column SHALL advance 0->1->2->3->0 (key_col 1110->1101->1011->0111->1110).
REQ-013 After column 3 is sampled, a full scan SHALL complete (every 4*SCAN_DIV cycles) and be classified as NONE (no row low), SINGLE (exactly one key low, code=row*4+col) or MULTI (two or more keys low).
REQ-014 MULTI SHALL be treated as NONE in IDLE/DEBOUNCE and as key-present in PRESSED/RELEASE.
REQ-015 FSM states IDLE, DEBOUNCE, PRESSED, RELEASE; transitions are evaluated only at full-scan completion.
REQ-016 IDLE: SINGLE -> DEBOUNCE, candidate=code, count=1.
REQ-017 DEBOUNCE: SINGLE with same code increments count; when count reaches DEBOUNCE_SCANS -> PRESSED, key_code<=candidate, key_valid pulsed; a differing code or NONE -> IDLE, no pulse.
REQ-018 PRESSED: key_held=1; NONE -> RELEASE, count=1; any key-present scan stays in PRESSED with no new event.
REQ-019 RELEASE: NONE increments count; on reaching DEBOUNCE_SCANS -> IDLE, key_held<=0; any key-present scan -> PRESSED, no pulse.
REQ-020 key_valid SHALL assert exactly one cycle, in the cycle after the qualifying scan completes.
REQ-021 key_code SHALL hold its value until the next key_valid.
REQ-022 With DEBOUNCE_SCANS=1, a press SHALL be accepted on the first SINGLE scan.

Reset
REQ-023 Reset asserted: key_col=1110, key_code=0, key_valid=0, key_held=0, state IDLE, all counters 0.
REQ-024 Reset mid-debounce or mid-press SHALL discard candidate and produce no key_valid; scanning restarts at column 0 on release of reset.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN defined: in PRESSED, key_valid SHALL re-pulse with the same key_code REPEAT_DELAY scans after acceptance, then every REPEAT_RATE scans while held; the repeat counter clears on leaving PRESSED.
REQ-026 Macro undefined: exactly one key_valid per press; REPEAT_* parameters are ignored and no repeat logic is built.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, column/row count (4), and key code width (4).
REQ-028 Divider and column one-hot driver SHALL be sub-module keypad_scan_timer, issuing sample and scan_done strobes.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-029 Reset asserted -> key_col=1110, key_code=0, key_valid=0, key_held=0.
REQ-030 Key row1/col2 held stable -> one key_valid pulse one cycle after 3rd full scan, key_code=6, key_held=1.
REQ-031 Key present 2 scans then released -> no key_valid, key_held stays 0.
REQ-032 Keys 0 and 5 pressed together from IDLE -> no key_valid.
REQ-033 Release after acceptance -> key_held falls after 3 NONE scans; re-press of key 6 -> second key_valid pulse.
REQ-034 KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, key held -> key_valid at acceptance, then +5, +7, +9 scans, key_code=6 each time.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned CODE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_class_e;

  // Number of rows pulled low in an active-low row vector.
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows_n);
    logic [2:0] n;
    n = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!rows_n[r]) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad matrix pins plus decoded key event outputs.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] key_col;
  logic [NUM_ROWS-1:0] key_row;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid;
  logic                key_held;

  modport master (
    output key_col, key_code, key_valid, key_held,
    input  key_row
  );

  modport slave (
    input  key_col, key_code, key_valid, key_held,
    output key_row
  );
endinterface

// File: rtl/keypad_scan_timer.sv
// Column dwell divider and active-low one-hot column driver.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic                clk,
  input  logic                reset,
  output logic [COL_W-1:0]    col_idx,
  output logic [NUM_COLS-1:0] key_col,
  output logic                sample,
  output logic                scan_done
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_q;
  logic [COL_W-1:0] col_q;

  assign sample    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign scan_done = sample && (col_q == COL_W'(NUM_COLS - 1));
  assign col_idx   = col_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      col_q <= '0;
    end else if (sample) begin
      div_q <= '0;
      col_q <= col_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    key_col        = '1;
    key_col[col_q] = 1'b0;
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner with debounce; optional auto-repeat when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  keypad_matrix_scanner_if.master  kp
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_matrix_scanner: parameter out of range");
  end

  logic [COL_W-1:0]    col_idx;
  logic [NUM_COLS-1:0] col_drive;
  logic                sample, scan_done;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .col_idx   (col_idx),
    .key_col   (col_drive),
    .sample    (sample),
    .scan_done (scan_done)
  );

  // Rows are asynchronous to clk; two flops settle well inside a column dwell.
  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.key_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Per-scan key count saturates at 2 (anything above one key is MULTI).
  logic [1:0]        acc_n_q, scan_n;
  logic [CODE_W-1:0] acc_code_q, scan_code;
  logic [2:0]        col_keys, sum;
  logic [COL_W-1:0]  hit_row;
  scan_class_e       scan_cls;

  always_comb begin
    col_keys = count_low(row_sync_q);
    hit_row  = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync_q[r]) hit_row = COL_W'(r);
    end
    sum       = {1'b0, acc_n_q} + col_keys;
    scan_n    = (sum > 3'd1) ? 2'd2 : sum[1:0];
    scan_code = (col_keys != '0) ? {hit_row, col_idx} : acc_code_q;
    case (scan_n)
      2'd0:    scan_cls = SCAN_NONE;
      2'd1:    scan_cls = SCAN_SINGLE;
      default: scan_cls = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_n_q    <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      if (scan_done) begin
        acc_n_q    <= '0;
        acc_code_q <= '0;
      end else begin
        acc_n_q    <= scan_n;
        acc_code_q <= scan_code;
      end
    end
  end

  kp_state_e         state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [CODE_W-1:0] cand_q, cand_d, code_q, code_d;
  logic              valid_q, valid_d, held_q, held_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_cls == SCAN_SINGLE) begin
            cand_d = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_PRESSED;
              code_d  = scan_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              deb_d   = DEB_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (scan_cls == SCAN_SINGLE && scan_code == cand_q) begin
            if (deb_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
              state_d = ST_PRESSED;
              deb_d   = '0;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            deb_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (scan_cls == SCAN_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_IDLE;
              held_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
              deb_d   = DEB_W'(1);
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (REP_W'(rep_q + 1'b1) == (rep_first_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
              valid_d     = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (scan_cls == SCAN_NONE) begin
            if (deb_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
              state_d = ST_IDLE;
              deb_d   = '0;
              held_d  = 1'b0;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d = ST_PRESSED;
            deb_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_d != ST_PRESSED) begin
      rep_d       = '0;
      rep_first_d = 1'b0;
    end
`endif
  end

  assign kp.key_col   = col_drive;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: directed scan table, reset corner cases, randomized scans vs. a key-event model.
module tb_keypad_matrix_scanner;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DS       = 3;
  localparam int unsigned RD       = 5;
  localparam int unsigned RR       = 2;
  localparam int unsigned CYC_SCAN = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pressed = '0;
  int n_cmp = 0;
  int n_bad = 0;

  keypad_matrix_scanner_if kp ();

  keypad_matrix_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .kp(kp)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its column.
  always_comb begin
    kp.key_row = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[r*4+c] && !kp.key_col[c]) kp.key_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key events derived from runs of scan results.
  bit m_held;
  int m_run_len, m_run_code, m_none_run, m_since, m_code;

  task automatic model_reset();
    m_held = 0; m_run_len = 0; m_run_code = 0; m_none_run = 0; m_since = 0; m_code = 0;
  endtask

  task automatic model_scan(input logic [15:0] mask, output bit fire);
    int n, code;
    n = $countones(mask);
    code = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = i;
    fire = 0;
    if (!m_held) begin
      if (m_run_len > 0) begin
        if (n == 1 && code == m_run_code) m_run_len++;
        else m_run_len = 0;
      end else if (n == 1) begin
        m_run_code = code;
        m_run_len = 1;
      end
      if (m_run_len == DS) begin
        fire = 1; m_code = m_run_code; m_held = 1;
        m_run_len = 0; m_none_run = 0; m_since = 0;
      end
    end else if (n == 0) begin
      m_none_run++;
      m_since = 0;
      if (m_none_run == DS) begin m_held = 0; m_none_run = 0; end
    end else if (m_none_run > 0) begin
      m_none_run = 0;
    end else begin
      m_since++;
`ifdef KEYPAD_REPEAT_EN
      if (m_since == RD || (m_since > RD && (m_since - RD) % RR == 0)) fire = 1;
`endif
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_key_col", kp.key_col, 4'b1110);
    check("rst_key_code", kp.key_code, 0);
    check("rst_key_valid", kp.key_valid, 0);
    check("rst_key_held", kp.key_held, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("rst_valid_during", kp.key_valid, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_scan(input logic [15:0] mask, output logic v, output logic h, output logic [3:0] c);
    pressed = mask;
    for (int i = 1; i <= int'(CYC_SCAN); i++) begin
      @(posedge clk);
      #1;
      if (i < int'(CYC_SCAN)) check("valid_mid_scan", kp.key_valid, 0);
    end
    v = kp.key_valid; h = kp.key_held; c = kp.key_code;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        valid;
    logic [3:0]  code;
    logic        held;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [15:0] m, input logic v, input logic [3:0] c, input logic h);
    vec_t e;
    e.mask = m; e.valid = v; e.code = c; e.held = h;
    tbl.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, h;
    logic [3:0] c, exp_col;
    logic [15:0] mask;
    bit fire;
    int len, kind, k1, k2;

    do_reset();

    pressed = '0;
    for (int i = 1; i <= int'(CYC_SCAN); i++) begin
      @(posedge clk);
      #1;
      exp_col = 4'b1111 & ~(4'b0001 << ((i / SCAN_DIV) % 4));
      if (i == 1 || i % SCAN_DIV == 0) check("col_walk", kp.key_col, exp_col);
    end

    add(16'h0040, 0, 4'd0, 0); add(16'h0040, 0, 4'd0, 0); add(16'h0040, 1, 4'd6, 1);
    add(16'h0040, 0, 4'd6, 1); add(16'h0000, 0, 4'd6, 1); add(16'h0000, 0, 4'd6, 1);
    add(16'h0000, 0, 4'd6, 0); add(16'h0040, 0, 4'd6, 0); add(16'h0040, 0, 4'd6, 0);
    add(16'h0040, 1, 4'd6, 1); add(16'h0000, 0, 4'd6, 1); add(16'h0000, 0, 4'd6, 1);
    add(16'h0000, 0, 4'd6, 0); add(16'h0200, 0, 4'd6, 0); add(16'h0200, 0, 4'd6, 0);
    add(16'h0000, 0, 4'd6, 0); add(16'h0021, 0, 4'd6, 0); add(16'h0021, 0, 4'd6, 0);
    add(16'h0021, 0, 4'd6, 0); add(16'h0008, 0, 4'd6, 0); add(16'h0008, 0, 4'd6, 0);
    add(16'h1000, 0, 4'd6, 0); add(16'h1000, 0, 4'd6, 0); add(16'h1000, 0, 4'd6, 0);
    add(16'h1000, 1, 4'd12, 1); add(16'h1001, 0, 4'd12, 1); add(16'h0000, 0, 4'd12, 1);
    add(16'h0020, 0, 4'd12, 1); add(16'h0000, 0, 4'd12, 1); add(16'h0000, 0, 4'd12, 1);
    add(16'h0000, 0, 4'd12, 0);
    foreach (tbl[i]) begin
      run_scan(tbl[i].mask, v, h, c);
      check($sformatf("tbl%0d_valid", i), v, tbl[i].valid);
      check($sformatf("tbl%0d_code", i), c, tbl[i].code);
      check($sformatf("tbl%0d_held", i), h, tbl[i].held);
    end

    // Reset two scans into a debounce, then restart the count from scratch.
    do_reset();
    run_scan(16'h0040, v, h, c); check("md_s1_valid", v, 0);
    run_scan(16'h0040, v, h, c); check("md_s2_valid", v, 0);
    repeat (5) @(posedge clk);
    #1 do_reset();
    run_scan(16'h0040, v, h, c); check("md_r1_valid", v, 0);
    run_scan(16'h0040, v, h, c); check("md_r2_valid", v, 0);
    run_scan(16'h0040, v, h, c); check("md_r3_valid", v, 1);
    check("md_r3_code", c, 6); check("md_r3_held", h, 1);

    // Reset while pressed drops key_held without a new event.
    repeat (7) @(posedge clk);
    #1 do_reset();
    run_scan(16'h0000, v, h, c);
    check("mp_valid", v, 0); check("mp_held", h, 0); check("mp_code", c, 0);

`ifdef KEYPAD_REPEAT_EN
    do_reset();
    for (int s = 1; s <= 12; s++) begin
      run_scan(16'h0040, v, h, c);
      check($sformatf("rep_s%0d_valid", s), v, (s == 3 || s == 8 || s == 10 || s == 12) ? 1 : 0);
      if (s >= 3) check($sformatf("rep_s%0d_code", s), c, 6);
    end
`endif

    do_reset();
    mask = '0;
    for (int seg = 0; seg < 150; seg++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (kind <= 2) mask = '0;
      else if (kind <= 6) mask = 16'(1) << $urandom_range(0, 15);
      else if (kind <= 8) begin
        k1 = $urandom_range(0, 15);
        k2 = (k1 + $urandom_range(1, 15)) % 16;
        mask = (16'(1) << k1) | (16'(1) << k2);
      end
      for (int s = 0; s < len; s++) begin
        model_scan(mask, fire);
        run_scan(mask, v, h, c);
        check("rnd_valid", v, fire);
        check("rnd_held", h, m_held);
        check("rnd_code", c, m_code);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
